// File: rtl/npc_wb_pkg.sv
// Shared types for the NPC GPR writeback path: data width, FSM states,
// writeback source ids and the rd/data request bundle.
package npc_wb_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALT
    } wb_state_t;

    typedef enum logic {
        SRC_EXU,
        SRC_LSU
    } wb_src_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/gpr_wb_rr2.sv
// Two-requester round-robin grant (EXU vs LSU) holding the last-winner flag.
// Ports: i_clk, i_rst_n, i_en_* (source may be granted), i_req_* (valid),
//        o_rdy_* (ready, independent of the source's own valid).
module gpr_wb_rr2
    import npc_wb_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en_exu,
    input  logic i_en_lsu,
    input  logic i_req_exu,
    input  logic i_req_lsu,
    output logic o_rdy_exu,
    output logic o_rdy_lsu
);

    wb_src_t r_last;
    logic    w_want_exu;
    logic    w_want_lsu;

    assign w_want_exu = i_en_exu && i_req_exu;
    assign w_want_lsu = i_en_lsu && i_req_lsu;

    // On a tie the source that did not win last time goes first.
    assign o_rdy_exu = i_en_exu && (!w_want_lsu || r_last == SRC_LSU);
    assign o_rdy_lsu = i_en_lsu && (!w_want_exu || r_last == SRC_EXU);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= SRC_LSU;
        end else if (w_want_exu && o_rdy_exu) begin
            r_last <= SRC_EXU;
        end else if (w_want_lsu && o_rdy_lsu) begin
            r_last <= SRC_LSU;
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Shares the GPR write port between EXU and LSU, counts loads in flight and
// sequences ebreak: drain pending loads, then raise sticky halt.
// Ports: clock/reset (async, active-low); exu_* and lsu_* valid/ready
// writeback channels; lsu_issue/lsu_issue_ready load issue throttle;
// rf_wen/rf_waddr/rf_wdata registered write port; halt to the sim model.
// Optional: define GPR_WB_STAT_EN to add stat_exu/stat_lsu/stat_conf.
module gpr_wb_arbiter
    import npc_wb_pkg::*;
#(
    parameter int MAX_OUTST = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            exu_valid,
    output logic            exu_ready,
    input  logic [4:0]      exu_rd,
    input  logic [XLEN-1:0] exu_data,
    input  logic            exu_ebreak,
    input  logic            lsu_issue,
    output logic            lsu_issue_ready,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            halt
`ifdef GPR_WB_STAT_EN
    ,
    output logic [63:0]     stat_exu,
    output logic [63:0]     stat_lsu,
    output logic [63:0]     stat_conf
`endif
);

    localparam int CW = $clog2(MAX_OUTST + 1);

    wb_state_t       r_state;
    logic [CW-1:0]   r_outst;
    logic            r_halt;
    logic            r_wen;
    logic [4:0]      r_waddr;
    logic [XLEN-1:0] r_wdata;

    logic    w_run;
    logic    w_drain;
    logic    w_acc_exu;
    logic    w_acc_lsu;
    logic    w_inc;
    logic    w_dec;
    logic    w_wen;
    wb_req_t w_req;

    assign w_run   = (r_state == RUN);
    assign w_drain = (r_state == DRAIN);

    gpr_wb_rr2 u_rr (
        .i_clk     (clock),
        .i_rst_n   (reset),
        .i_en_exu  (w_run),
        .i_en_lsu  (w_run || w_drain),
        .i_req_exu (exu_valid),
        .i_req_lsu (lsu_valid),
        .o_rdy_exu (exu_ready),
        .o_rdy_lsu (lsu_ready)
    );

    assign w_acc_exu = exu_valid && exu_ready;
    assign w_acc_lsu = lsu_valid && lsu_ready;

    assign lsu_issue_ready = w_run && (r_outst < CW'(MAX_OUTST));

    assign w_inc = lsu_issue && lsu_issue_ready;
    // A load return with nothing outstanding is dropped from the count.
    assign w_dec = w_acc_lsu && (r_outst != '0);

    always_comb begin
        w_req.rd   = lsu_rd;
        w_req.data = lsu_data;
        if (w_acc_exu) begin
            w_req.rd   = exu_rd;
            w_req.data = exu_data;
        end
    end

    // x0 writes and ebreak beats are consumed without touching the file.
    assign w_wen = (w_acc_exu && !exu_ebreak && exu_rd != 5'd0)
                || (w_acc_lsu && lsu_rd != 5'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= w_wen;
            if (w_wen) begin
                r_waddr <= w_req.rd;
                r_wdata <= w_req.data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_outst <= '0;
        end else if (w_inc && !w_dec) begin
            r_outst <= r_outst + CW'(1);
        end else if (w_dec && !w_inc) begin
            r_outst <= r_outst - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_halt  <= 1'b0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (w_acc_exu && exu_ebreak) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_outst == '0 && !w_acc_lsu) begin
                        r_state <= HALT;
                        r_halt  <= 1'b1;
                    end
                end
                HALT: begin
                    r_halt <= 1'b1;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign rf_wen   = r_wen;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;
    assign halt     = r_halt;

`ifdef GPR_WB_STAT_EN
    logic [63:0] r_exu_wr_cnt;
    logic [63:0] r_lsu_wr_cnt;
    logic [63:0] r_conflict_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_exu_wr_cnt   <= '0;
            r_lsu_wr_cnt   <= '0;
            r_conflict_cnt <= '0;
        end else if (r_state != HALT) begin
            if (w_acc_exu) begin
                r_exu_wr_cnt <= r_exu_wr_cnt + 64'd1;
            end
            if (w_acc_lsu) begin
                r_lsu_wr_cnt <= r_lsu_wr_cnt + 64'd1;
            end
            if (exu_valid && lsu_valid) begin
                r_conflict_cnt <= r_conflict_cnt + 64'd1;
            end
        end
    end

    assign stat_exu  = r_exu_wr_cnt;
    assign stat_lsu  = r_lsu_wr_cnt;
    assign stat_conf = r_conflict_cnt;
`endif

`ifndef SYNTHESIS
    a_lsu_underflow: assert property (
        @(posedge clock) disable iff (!reset)
        !(w_acc_lsu && r_outst == '0)
    );
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Scoreboard bench for gpr_wb_arbiter: a cycle model predicts readies,
// queues the expected register-file write and checks it one cycle later.
module tb_gpr_wb_arbiter;

    localparam int MAXO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        exu_valid = 1'b0;
    logic        exu_ready;
    logic [4:0]  exu_rd = '0;
    logic [63:0] exu_data = '0;
    logic        exu_ebreak = 1'b0;
    logic        lsu_issue = 1'b0;
    logic        lsu_issue_ready;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = '0;
    logic [63:0] lsu_data = '0;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        halt;
`ifdef GPR_WB_STAT_EN
    logic [63:0] stat_exu;
    logic [63:0] stat_lsu;
    logic [63:0] stat_conf;
`endif

    gpr_wb_arbiter #(.MAX_OUTST(MAXO)) dut (
        .clock           (clock),
        .reset           (reset),
        .exu_valid       (exu_valid),
        .exu_ready       (exu_ready),
        .exu_rd          (exu_rd),
        .exu_data        (exu_data),
        .exu_ebreak      (exu_ebreak),
        .lsu_issue       (lsu_issue),
        .lsu_issue_ready (lsu_issue_ready),
        .lsu_valid       (lsu_valid),
        .lsu_ready       (lsu_ready),
        .lsu_rd          (lsu_rd),
        .lsu_data        (lsu_data),
        .rf_wen          (rf_wen),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .halt            (halt)
`ifdef GPR_WB_STAT_EN
        ,
        .stat_exu        (stat_exu),
        .stat_lsu        (stat_lsu),
        .stat_conf       (stat_conf)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        wen;
        logic [4:0]  addr;
        logic [63:0] data;
    } exp_t;

    exp_t sbq[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference state: 0 RUN, 1 DRAIN, 2 HALT.
    int          m_state;
    bit          m_last_lsu;
    int          m_outst;
    bit          m_halt;
    logic [63:0] s_exu;
    logic [63:0] s_lsu;
    logic [63:0] s_conf;

    bit          a_e;
    bit          a_l;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit ev, input logic [4:0] erd,
                        input logic [63:0] ed, input bit eeb,
                        input bit li, input bit lv,
                        input logic [4:0] lrd, input logic [63:0] ld,
                        output bit ae, output bit al);
        exp_t e;
        bit er, lr, ir;
        exu_valid  = ev;
        exu_rd     = erd;
        exu_data   = ed;
        exu_ebreak = eeb;
        lsu_issue  = li;
        lsu_valid  = lv;
        lsu_rd     = lrd;
        lsu_data   = ld;
        @(negedge clock);
        if (sbq.size() > 0) e = sbq.pop_front();
        else e = '{1'b0, 5'd0, 64'd0};
        chk("rf_wen", 64'(rf_wen), 64'(e.wen));
        if (e.wen) begin
            chk("rf_waddr", 64'(rf_waddr), 64'(e.addr));
            chk("rf_wdata", rf_wdata, e.data);
        end
        chk("halt", 64'(halt), 64'(m_halt));
        er = (m_state == 0) && (!lv || m_last_lsu);
        lr = (m_state == 1) || ((m_state == 0) && (!ev || !m_last_lsu));
        ir = (m_state == 0) && (m_outst < MAXO);
        chk("exu_ready", 64'(exu_ready), 64'(er));
        chk("lsu_ready", 64'(lsu_ready), 64'(lr));
        chk("issue_ready", 64'(lsu_issue_ready), 64'(ir));
        ae = ev && er;
        al = lv && lr;
        e.wen  = (ae && !eeb && erd != 5'd0) || (al && lrd != 5'd0);
        e.addr = ae ? erd : lrd;
        e.data = ae ? ed : ld;
        sbq.push_back(e);
        if (m_state != 2) begin
            if (ae) s_exu = s_exu + 64'd1;
            if (al) s_lsu = s_lsu + 64'd1;
            if (ev && lv) s_conf = s_conf + 64'd1;
        end
        if (ae) m_last_lsu = 1'b0;
        else if (al) m_last_lsu = 1'b1;
        if (m_state == 1 && m_outst == 0 && !al) begin
            m_state = 2;
            m_halt  = 1'b1;
        end else if (m_state == 0 && ae && eeb) begin
            m_state = 1;
        end
        if (li && ir) m_outst++;
        if (al && m_outst > 0) m_outst--;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        bit x, y;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, x, y);
    endtask

    task automatic issue(input int n);
        bit x, y;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0, 0, 0, x, y);
    endtask

    task automatic do_reset();
        exu_valid  = 1'b0;
        exu_ebreak = 1'b0;
        lsu_issue  = 1'b0;
        lsu_valid  = 1'b0;
        reset      = 1'b0;
        #2;
        chk("rst_halt", 64'(halt), 64'd0);
        chk("rst_wen", 64'(rf_wen), 64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_wdata", rf_wdata, 64'd0);
        m_state    = 0;
        m_last_lsu = 1'b1;
        m_outst    = 0;
        m_halt     = 1'b0;
        s_exu      = '0;
        s_lsu      = '0;
        s_conf     = '0;
        sbq.delete();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    bit          pe, pl, rli;
    logic [4:0]  pe_rd, pl_rd;
    logic [63:0] pe_d, pl_d;

    initial begin
        #1;
        do_reset();
        idle(1);

        // Tie-break: EXU first, then alternate.
        issue(2);
        for (int i = 0; i < 4; i++)
            step(1, 5'd1, 64'hA1, 0, 0, 1, 5'd2, 64'hB2, a_e, a_l);
        idle(1);

        step(1, 5'd5, 64'h1234, 0, 0, 0, 0, 0, a_e, a_l);
        idle(1);
        step(1, 5'd0, 64'hFFFF, 0, 0, 0, 0, 0, a_e, a_l);
        idle(1);

        // Random traffic with valid held until accepted.
        pe = 0;
        pl = 0;
        for (int i = 0; i < 80; i++) begin
            if (!pe && $urandom_range(0, 2) != 0) begin
                pe    = 1;
                pe_rd = 5'($urandom);
                pe_d  = {$urandom, $urandom};
            end
            if (!pl && m_outst > 0 && $urandom_range(0, 1) != 0) begin
                pl    = 1;
                pl_rd = 5'($urandom);
                pl_d  = {$urandom, $urandom};
            end
            rli = ($urandom_range(0, 1) != 0);
            step(pe, pe_rd, pe_d, 0, rli, pl, pl_rd, pl_d, a_e, a_l);
            if (a_e) pe = 0;
            if (a_l) pl = 0;
        end

        // Outstanding-load limit.
        do_reset();
        issue(5);
        step(0, 0, 0, 0, 0, 1, 5'd7, 64'h77, a_e, a_l);
        step(0, 0, 0, 0, 1, 1, 5'd8, 64'h88, a_e, a_l);
        issue(1);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 5'd8, 64'h81, a_e, a_l);
        step(0, 0, 0, 0, 0, 1, 5'd9, 64'h91, a_e, a_l);

        // ebreak with two loads pending, EXU held off during drain.
        step(1, 5'd3, 64'hEB, 1, 0, 0, 0, 0, a_e, a_l);
        step(1, 5'd9, 64'h99, 0, 1, 1, 5'd10, 64'hA0, a_e, a_l);
        step(1, 5'd9, 64'h99, 0, 0, 1, 5'd11, 64'hB0, a_e, a_l);
        for (int i = 0; i < 4; i++)
            step(1, 5'd9, 64'h99, 0, 1, 0, 0, 0, a_e, a_l);

        // ebreak colliding with a load return, then reset mid-drain.
        do_reset();
        issue(3);
        step(1, 5'd0, 64'h0, 1, 0, 1, 5'd12, 64'hC0, a_e, a_l);
        step(0, 0, 0, 0, 0, 1, 5'd12, 64'hC0, a_e, a_l);
        idle(1);
        do_reset();
        step(1, 5'd3, 64'hABC, 0, 0, 0, 0, 0, a_e, a_l);
        issue(1);
        idle(1);

`ifdef GPR_WB_STAT_EN
        chk("stat_exu", stat_exu, s_exu);
        chk("stat_lsu", stat_lsu, s_lsu);
        chk("stat_conf", stat_conf, s_conf);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
